// File: rtl/pulse_event_accumulator.sv
// Counts single-cycle event pulses over a fixed window, or until a threshold is reached, and
// reports each non-zero count on a valid/ready interface. Pulses that arrive while a report is stalled are kept, saturating.
module pulse_event_accumulator #(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned WINDOW = 16,
    parameter int unsigned THRESH = 8
) (
    input  logic             clk_b,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic             enable,
    output logic [CNT_W-1:0] evt_count,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             evt_ovf,
    output logic             busy
);

    localparam int unsigned TW = $clog2(WINDOW);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] evt_count_q, evt_count_d;
    logic             evt_valid_q, evt_valid_d;
    logic             evt_ovf_q, evt_ovf_d;
    logic             busy_q, busy_d;

    logic             sat;
    logic [CNT_W-1:0] acc_next;
    logic             trig;

    always_comb begin
        sat      = pulse_in && (acc_q == '1);
        acc_next = sat ? acc_q : acc_q + {{(CNT_W-1){1'b0}}, pulse_in};
        trig     = (acc_next >= CNT_W'(THRESH)) || (timer_q == TW'(WINDOW - 1));

        state_d     = state_q;
        acc_d       = acc_q;
        timer_d     = timer_q;
        ovf_d       = ovf_q;
        evt_count_d = evt_count_q;
        evt_valid_d = evt_valid_q;
        evt_ovf_d   = evt_ovf_q;

        case (state_q)
            IDLE: begin
                acc_d   = '0;
                timer_d = '0;
                ovf_d   = 1'b0;
                if (enable) state_d = ACCUM;
            end
            ACCUM: begin
                if (!enable) begin
                    acc_d   = '0;
                    timer_d = '0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end else if (trig && (acc_next != '0)) begin
                    evt_count_d = acc_next;
                    evt_ovf_d   = ovf_q | sat;
                    evt_valid_d = 1'b1;
                    acc_d       = '0;
                    timer_d     = '0;
                    ovf_d       = 1'b0;
                    state_d     = HOLD;
                end else if (trig) begin
                    // Empty window: restart the window without emitting a zero report.
                    timer_d = '0;
                end else begin
                    acc_d   = acc_next;
                    timer_d = timer_q + 1'b1;
                    ovf_d   = ovf_q | sat;
                end
            end
            HOLD: begin
                acc_d = acc_next;
                ovf_d = ovf_q | sat;
                if (evt_ready) begin
                    evt_valid_d = 1'b0;
                    timer_d     = '0;
                    if (enable) begin
                        state_d = ACCUM;
                    end else begin
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_b or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            timer_q     <= '0;
            ovf_q       <= 1'b0;
            evt_count_q <= '0;
            evt_valid_q <= 1'b0;
            evt_ovf_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            timer_q     <= timer_d;
            ovf_q       <= ovf_d;
            evt_count_q <= evt_count_d;
            evt_valid_q <= evt_valid_d;
            evt_ovf_q   <= evt_ovf_d;
            busy_q      <= busy_d;
        end
    end

    assign evt_count = evt_count_q;
    assign evt_valid = evt_valid_q;
    assign evt_ovf   = evt_ovf_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_pulse_event_accumulator.sv
// Scoreboard bench for pulse_event_accumulator: a reference model built on raw (unbounded) pulse counts
// queues expected reports; a negedge monitor checks status and pops a report on each handshake.
module tb_pulse_event_accumulator;

    localparam int CNT_W  = 4;
    localparam int WINDOW = 16;
    localparam int THRESH = 8;
    localparam int CAP    = (1 << CNT_W) - 1;

    logic             clk_b = 1'b0;
    logic             rst = 1'b0;
    logic             pulse_in = 1'b0;
    logic             enable = 1'b0;
    logic             evt_ready = 1'b0;
    logic [CNT_W-1:0] evt_count;
    logic             evt_valid;
    logic             evt_ovf;
    logic             busy;

    pulse_event_accumulator #(.CNT_W(CNT_W), .WINDOW(WINDOW), .THRESH(THRESH)) dut (
        .clk_b     (clk_b),
        .rst       (rst),
        .pulse_in  (pulse_in),
        .enable    (enable),
        .evt_count (evt_count),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ovf   (evt_ovf),
        .busy      (busy)
    );

    always #5 clk_b = ~clk_b;

    typedef struct {
        int cnt;
        bit ovf;
    } rep_t;

    rep_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   m_mode = 0;     // 0 idle, 1 counting, 2 waiting for consumer
    int   m_raw = 0;      // pulses collected, never clipped
    int   m_age = 0;      // cycles already spent in the current window
    int   mode_now = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_mode = 0;
        m_raw  = 0;
        m_age  = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input bit p, input bit en, input bit rdy);
        int   n;
        rep_t r;
        case (m_mode)
            0: begin
                m_raw = 0;
                m_age = 0;
                if (en) m_mode = 1;
            end
            1: begin
                if (!en) begin
                    m_mode = 0;
                    m_raw  = 0;
                    m_age  = 0;
                end else begin
                    n = m_raw + int'(p);
                    if (n >= THRESH || m_age == WINDOW - 1) begin
                        if (n > 0) begin
                            r.cnt = (n > CAP) ? CAP : n;
                            r.ovf = (n > CAP);
                            exp_q.push_back(r);
                            m_mode = 2;
                        end
                        m_raw = 0;
                        m_age = 0;
                    end else begin
                        m_raw = n;
                        m_age++;
                    end
                end
            end
            default: begin
                m_raw += int'(p);
                if (rdy) begin
                    m_age = 0;
                    if (en) m_mode = 1;
                    else begin
                        m_mode = 0;
                        m_raw  = 0;
                    end
                end
            end
        endcase
    endtask

    task automatic step(input bit p, input bit en, input bit rdy);
        @(posedge clk_b);
        #1;
        mode_now  = m_mode;
        pulse_in  = p;
        enable    = en;
        evt_ready = rdy;
        if (rst) model_step(p, en, rdy);
        else model_clear();
    endtask

    always @(negedge clk_b) begin
        rep_t r;
        if (mon_en) begin
            check("busy", int'(busy), int'(mode_now != 0));
            check("evt_valid", int'(evt_valid), int'(mode_now == 2));
            if (evt_valid && exp_q.size() > 0)
                check("evt_count_held", int'(evt_count), exp_q[0].cnt);
            if (evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_report: got count %0d, expected no report", evt_count);
                end else begin
                    r = exp_q.pop_front();
                    check("evt_count", int'(evt_count), r.cnt);
                    check("evt_ovf", int'(evt_ovf), int'(r.ovf));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk_b);
        #1;
        check("rst_evt_valid", int'(evt_valid), 0);
        check("rst_evt_count", int'(evt_count), 0);
        check("rst_evt_ovf", int'(evt_ovf), 0);
        check("rst_busy", int'(busy), 0);
        rst    = 1'b1;
        mon_en = 1'b1;

        // Sparse pulses reported at window expiry.
        step(0, 1, 1);
        repeat (3) begin
            step(1, 1, 1);
            step(0, 1, 1);
        end
        repeat (30) step(0, 1, 1);

        // Continuous pulses: threshold reports back-to-back.
        repeat (40) step(1, 1, 1);

        // Stalled consumer with continuous pulses: saturation and overflow.
        repeat (45) step(1, 1, 0);
        repeat (30) step(1, 1, 1);

        // Idle windows produce no report.
        repeat (3 * WINDOW) step(0, 1, 1);

        // Drop enable mid-accumulation, then mid-report.
        repeat (3) step(0, 0, 1);
        step(0, 1, 1);
        repeat (5) step(1, 1, 1);
        repeat (4) step(0, 0, 1);
        step(0, 1, 0);
        repeat (10) step(1, 1, 0);
        repeat (5) step(0, 0, 0);
        step(1, 0, 1);
        repeat (4) step(0, 0, 1);

        // Random traffic.
        repeat (1500)
            step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 19) != 0),
                 bit'($urandom_range(0, 3) != 0));

        // Asynchronous reset while a report is pending.
        repeat (3) step(0, 0, 1);
        step(0, 1, 0);
        repeat (10) step(1, 1, 0);
        #2;
        rst = 1'b0;
        model_clear();
        mode_now = 0;
        #1;
        check("arst_evt_valid", int'(evt_valid), 0);
        check("arst_evt_count", int'(evt_count), 0);
        check("arst_evt_ovf", int'(evt_ovf), 0);
        check("arst_busy", int'(busy), 0);
        step(0, 0, 0);
        rst = 1'b1;
        step(0, 1, 1);
        repeat (3) begin
            step(1, 1, 1);
            step(0, 1, 1);
        end
        repeat (30) step(0, 1, 1);

        repeat (5) step(0, 0, 1);
        check("reports_drained", exp_q.size(), 0);
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
